// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   DMEM_DEPTH / DMEM_AW : default memory geometry (256 words, 8-bit index)
//   PORT_CORE / PORT_DMA : requester indices used by the winner signal
//   state_e              : sequencer states
//   acc_t                : the request latched at accept time
//   addr_ok()            : range check against a given depth
package dmem_pkg;

    localparam int   DMEM_DEPTH = 256;
    localparam int   DMEM_AW    = 8;
    localparam logic PORT_CORE  = 1'b0;
    localparam logic PORT_DMA   = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // One in-flight access. err marks an out-of-range address: the access
    // still completes (done + err) but never touches the memory.
    typedef struct packed {
        logic port;
        logic we;
        logic err;
    } acc_t;

    function automatic logic addr_ok(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way picker.
//   req[1:0]  : request vector, bit 0 = core, bit 1 = DMA
//   last      : port granted most recently
//   prio_mode : 1 = core wins every tie, 0 = the port not granted last wins
//   winner    : chosen port (only meaningful when some req bit is set)
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio_mode,
    output logic       winner
);

    always_comb begin
        winner = PORT_CORE;
        case (req)
            2'b01:   winner = PORT_CORE;
            2'b10:   winner = PORT_DMA;
            2'b11:   winner = prio_mode ? PORT_CORE : ~last;
            default: winner = PORT_CORE;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and access sequencer for a single-port
// data memory with combinational read and level-sensitive write.
//   clk, rst_n             : clock, asynchronous active-low reset
//   req/we/addr/wdata 0,1  : requests (port 0 = core, port 1 = DMA)
//   gnt0/gnt1              : one-cycle accept pulse
//   done0/done1            : one-cycle completion pulse
//   err0/err1              : completion with out-of-range address
//   rdata                  : read data, valid while a done is high
//   mem_addr/mem_wdata     : registered memory address / write data
//   mem_read/mem_write     : registered one-cycle strobes
//   mem_rdata              : memory read data
// Timeline of one access: accept edge -> gnt cycle (state ACCESS) -> strobe
// cycle (state back in IDLE, can already accept the next request) -> done.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH         = DMEM_DEPTH,
    parameter bit CORE_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    acc_t        acc_q, acc_d;
    logic        fin_q, fin_d;      // strobe cycle in progress, complete at its end
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    logic        winner;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_ok;

    rr_arb2 u_arb (
        .req       ({req1, req0}),
        .last      (last_q),
        .prio_mode (CORE_PRIORITY),
        .winner    (winner)
    );

    assign sel_we    = (winner == PORT_DMA) ? we1    : we0;
    assign sel_addr  = (winner == PORT_DMA) ? addr1  : addr0;
    assign sel_wdata = (winner == PORT_DMA) ? wdata1 : wdata0;
    assign sel_ok    = addr_ok(sel_addr, DEPTH);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        acc_d       = acc_q;
        fin_d       = 1'b0;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;

        // Completion of the access whose strobe is up now. mem_addr is still
        // the accepted address here, so mem_rdata belongs to this access even
        // if a new request is accepted on the same edge.
        if (fin_q) begin
            done0_d = (acc_q.port == PORT_CORE);
            done1_d = (acc_q.port == PORT_DMA);
            err0_d  = (acc_q.port == PORT_CORE) && acc_q.err;
            err1_d  = (acc_q.port == PORT_DMA) && acc_q.err;
            rdata_d = (!acc_q.we && !acc_q.err) ? mem_rdata : '0;
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    acc_d.port = winner;
                    acc_d.we   = sel_we;
                    acc_d.err  = !sel_ok;
                    last_d     = winner;
                    gnt0_d     = (winner == PORT_CORE);
                    gnt1_d     = (winner == PORT_DMA);
                    // Bus only moves for a legal address, so a later write
                    // strobe never sees a changing address.
                    if (sel_ok) begin
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_read_d  = !acc_q.we && !acc_q.err;
                mem_write_d = acc_q.we && !acc_q.err;
                fin_d       = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= PORT_DMA;
            acc_q       <= '0;
            fin_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            fin_q       <= fin_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance checked every cycle against
// a transaction-level model, plus a core-priority instance checked directly.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic        req0p, req1p;
    logic        gnt0p, gnt1p, done0p, done1p, err0p, err1p;
    logic [31:0] rdatap, mem_addrp, mem_wdatap;
    logic        mem_readp, mem_writep;
    logic [31:0] mem_rdatap;
    assign mem_rdatap = 32'h1234_5678;

    dmem_arbiter #(.DEPTH(256), .CORE_PRIORITY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata(rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.DEPTH(256), .CORE_PRIORITY(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .req0(req0p), .we0(1'b0), .addr0(32'd1), .wdata0(32'd0),
        .req1(req1p), .we1(1'b0), .addr1(32'd2), .wdata1(32'd0),
        .gnt0(gnt0p), .gnt1(gnt1p), .done0(done0p), .done1(done1p),
        .err0(err0p), .err1(err1p), .rdata(rdatap),
        .mem_addr(mem_addrp), .mem_read(mem_readp), .mem_write(mem_writep),
        .mem_wdata(mem_wdatap), .mem_rdata(mem_rdatap)
    );

    // ---------------- memory environment ----------------
    logic [31:0] mem [256];
    assign mem_rdata = mem[mem_addr[7:0]];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
        mem[4] = 32'd10;
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    // ---------------- counters / checks ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    // Each accept schedules its visible effects at fixed offsets: gnt right
    // after the accept edge, strobe one cycle later, done one cycle after that.
    typedef struct {
        bit        gnt0, gnt1, rd, wr, done0, done1, err0, err1, rdv;
        bit [31:0] rdval;
    } ev_t;
    ev_t ev [4096];

    int        cyc = 0;
    bit [31:0] ref_mem [256];
    bit        m_last;
    int        next_ok;
    bit        pend_wr;
    int        pend_edge;
    bit [7:0]  pend_a;
    bit [31:0] pend_d;
    bit [31:0] cur_maddr, cur_wdata, cur_rdata;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000 + i;
        ref_mem[4] = 32'd10;
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc >= 4090) begin
                $display("FAIL cycle_budget t=%0t", $time);
                $fatal(1);
            end
            if (!rst_n) begin
                for (int i = cyc; i < cyc + 4; i++) ev[i] = '{default: 0};
                m_last = 1'b1; next_ok = 0; pend_wr = 1'b0;
                cur_maddr = 0; cur_wdata = 0; cur_rdata = 0;
            end else begin
                if (pend_wr && pend_edge == cyc) begin
                    ref_mem[pend_a] = pend_d;
                    pend_wr = 1'b0;
                end
                if (ev[cyc].rdv) cur_rdata = ev[cyc].rdval;
                if (cyc >= next_ok && (req0 || req1)) begin
                    bit        p, w, inr;
                    bit [31:0] a, d;
                    if (req0 && req1) p = m_last ? 1'b0 : 1'b1;
                    else              p = req1;
                    w = p ? we1 : we0;
                    a = p ? addr1 : addr0;
                    d = p ? wdata1 : wdata0;
                    inr = (a < 256);
                    m_last  = p;
                    next_ok = cyc + 2;
                    if (p) ev[cyc].gnt1 = 1'b1; else ev[cyc].gnt0 = 1'b1;
                    if (inr) begin cur_maddr = a; cur_wdata = d; end
                    ev[cyc+1].rd = inr && !w;
                    ev[cyc+1].wr = inr && w;
                    if (p) begin ev[cyc+2].done1 = 1'b1; ev[cyc+2].err1 = !inr; end
                    else   begin ev[cyc+2].done0 = 1'b1; ev[cyc+2].err0 = !inr; end
                    ev[cyc+2].rdv   = 1'b1;
                    ev[cyc+2].rdval = (inr && !w) ? ref_mem[a[7:0]] : 32'd0;
                    if (inr && w) begin
                        pend_wr = 1'b1; pend_edge = cyc + 2; pend_a = a[7:0]; pend_d = d;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare + event log ----------------
    int        gnt_log[$];
    int        wr_cnt = 0, done_cnt = 0;
    int        t_gnt0 = -1, t_rd = -1, t_done0 = -1;
    logic [31:0] rd_addr, last_done_rdata;
    logic        last_done_err;
    int        cnt0p = 0, cnt1p = 0;

    always @(posedge clk) begin
        #1;
        chk1("gnt0", gnt0, ev[cyc].gnt0);
        chk1("gnt1", gnt1, ev[cyc].gnt1);
        chk1("mem_read", mem_read, ev[cyc].rd);
        chk1("mem_write", mem_write, ev[cyc].wr);
        chk1("done0", done0, ev[cyc].done0);
        chk1("done1", done1, ev[cyc].done1);
        chk1("err0", err0, ev[cyc].err0);
        chk1("err1", err1, ev[cyc].err1);
        chk32("rdata", rdata, cur_rdata);
        chk32("mem_addr", mem_addr, cur_maddr);
        chk32("mem_wdata", mem_wdata, cur_wdata);
        if (gnt0) begin gnt_log.push_back(0); t_gnt0 = cyc; end
        if (gnt1) gnt_log.push_back(1);
        if (mem_read) begin t_rd = cyc; rd_addr = mem_addr; end
        if (mem_write) wr_cnt++;
        if (done0 || done1) begin
            done_cnt++;
            last_done_rdata = rdata;
            last_done_err   = err0 | err1;
            if (done0) t_done0 = cyc;
        end
        if (gnt0p) cnt0p++;
        if (gnt1p) cnt1p++;
    end

    // ---------------- requester agents ----------------
    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
    } rq_t;
    rq_t q0[$], q1[$];

    initial begin
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        forever begin
            @(negedge clk);
            if (gnt0 && q0.size() > 0) void'(q0.pop_front());
            if (gnt1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                req0 = 1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata;
            end else req0 = 0;
            if (q1.size() > 0) begin
                req1 = 1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata;
            end else req1 = 0;
        end
    end

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !req0 && !req1) begin
                ok = 1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        chk1("drain_timeout", ok, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lg, wb, dc;
        bit seen;
        rst_n = 0; req0p = 0; req1p = 0;
        repeat (3) @(negedge clk);
        chk32("reset_mem_addr", mem_addr, 32'd0);
        chk32("reset_rdata", rdata, 32'd0);
        chk1("reset_gnt0", gnt0, 1'b0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // single read of mem[4] = 10
        q0.push_back('{we: 1'b0, addr: 32'd4, wdata: 32'd0});
        drain();
        chk32("rd_strobe_lat", t_rd - t_gnt0, 1);
        chk32("rd_done_lat", t_done0 - t_gnt0, 2);
        chk32("rd_addr", rd_addr, 32'd4);
        chk32("rd_data", last_done_rdata, 32'd10);

        // port 1 write then read back
        wb = wr_cnt;
        q1.push_back('{we: 1'b1, addr: 32'd7, wdata: 32'hDEADBEEF});
        q1.push_back('{we: 1'b0, addr: 32'd7, wdata: 32'd0});
        drain();
        chk32("wr_once", wr_cnt - wb, 1);
        chk32("wr_readback", last_done_rdata, 32'hDEADBEEF);

        // round-robin contention, 4 requests each
        lg = gnt_log.size();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{we: 1'b0, addr: 32'(10 + i), wdata: 32'd0});
            q1.push_back('{we: 1'b1, addr: 32'(20 + i), wdata: 32'(32'hA0 + i)});
        end
        drain();
        chk32("rr_count", gnt_log.size() - lg, 8);
        for (int i = 0; i < 8; i++)
            if (lg + i < gnt_log.size()) chk32("rr_order", gnt_log[lg + i], i % 2);

        // out-of-range write and read
        wb = wr_cnt;
        q1.push_back('{we: 1'b1, addr: 32'd256, wdata: 32'h55});
        drain();
        chk32("oor_no_write", wr_cnt - wb, 0);
        chk32("oor_addr_kept", mem_addr, 32'd23);
        chk1("oor_err", last_done_err, 1'b1);
        chk32("oor_rdata", last_done_rdata, 32'd0);
        q0.push_back('{we: 1'b0, addr: 32'hFFFF_FFFF, wdata: 32'd0});
        drain();
        chk1("oor_rd_err", last_done_err, 1'b1);
        chk32("oor_rd_rdata", last_done_rdata, 32'd0);

        // reset in the middle of a write
        wb = wr_cnt;
        q0.push_back('{we: 1'b1, addr: 32'd9, wdata: 32'hCAFEF00D});
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (gnt0) begin seen = 1; break; end
        end
        chk1("abort_gnt_seen", seen, 1'b1);
        @(negedge clk); #2;
        rst_n = 0;
        dc = done_cnt;
        @(posedge clk); #2;
        chk1("abort_no_write_strobe", mem_write, 1'b0);
        chk32("abort_mem_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk32("abort_no_done", done_cnt - dc, 0);
        chk32("abort_no_write", wr_cnt - wb, 0);
        q0.push_back('{we: 1'b0, addr: 32'd9, wdata: 32'd0});
        drain();
        chk32("abort_readback", last_done_rdata, 32'h0000_1009);

        // core-priority instance: req0 held, port 1 starves until it drops
        begin
            int b0, b1;
            b0 = cnt0p; b1 = cnt1p;
            req0p = 1; req1p = 1;
            repeat (10) @(negedge clk);
            chk32("prio_core_grants", cnt0p - b0, 5);
            chk32("prio_dma_starved", cnt1p - b1, 0);
            req0p = 0;
            @(posedge clk); #1;
            chk1("prio_dma_next", gnt1p, 1'b1);
            @(negedge clk);
            req1p = 0;
            repeat (4) @(negedge clk);
            chk32("prio_dma_once", cnt1p - b1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
